// File: rtl/adder_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// adder
//   Shared 6-bit unsigned adder datapath.
//   x, y : 6-bit operands
//   s    : 7-bit zero-extended sum, carry in bit 6
// ---------------------------------------------------------------------------
module adder (
    input  logic [5:0] x,
    input  logic [5:0] y,
    output logic [6:0] s
);

    assign s = {1'b0, x} + {1'b0, y};

endmodule

// ---------------------------------------------------------------------------
// adder_arbiter
//   Round-robin arbiter/sequencer sharing one adder between N_REQ requesters.
//   Each accepted operand pair goes IDLE -> CALC -> RESP; the registered sum
//   is returned tagged with the requester index.
//
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester operand-pair pending
//   req_x      : operand x, requester i in bits [6i+5:6i]
//   req_y      : operand y, same packing as req_x
//   req_ready  : one-hot (or zero) combinational grant, IDLE only
//   res_valid  : result available
//   res_sum    : registered x+y
//   res_id     : index of the requester that owns the result
//   res_ready  : consumer accepts the result
//   done_cnt   : completed result transfers, wraps at 16 bits
// ---------------------------------------------------------------------------
module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [6*N_REQ-1:0]   req_x,
    input  logic [6*N_REQ-1:0]   req_y,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 res_valid,
    output logic [6:0]           res_sum,
    output logic [ID_W-1:0]      res_id,
    input  logic                 res_ready,
    output logic [15:0]          done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Requester count at pointer width (+1 bit so rr_ptr+k cannot overflow).
    localparam logic [ID_W:0] N_REQ_W = N_REQ[ID_W:0];

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [5:0]      x_q;
    logic [5:0]      y_q;
    logic [6:0]      add_s;

    logic            found;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] next_ptr;
    logic [5:0]      win_x;
    logic [5:0]      win_y;

    adder u_adder (
        .x (x_q),
        .y (y_q),
        .s (add_s)
    );

    // Rotating priority search: first valid requester at or after rr_ptr.
    // Indices are wrapped explicitly so non-power-of-two N_REQ works.
    always_comb begin : arb_search
        logic [ID_W:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + k[ID_W:0];
            if (cand >= N_REQ_W) begin
                cand = cand - N_REQ_W;
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin : ptr_advance
        logic [ID_W:0] inc;
        inc = {1'b0, winner} + {{ID_W{1'b0}}, 1'b1};
        if (inc >= N_REQ_W) begin
            inc = '0;
        end
        next_ptr = inc[ID_W-1:0];
    end

    always_comb begin : operand_mux
        win_x = req_x[6*winner +: 6];
        win_y = req_y[6*winner +: 6];
    end

    // Grant is gated by rst_n so it is low throughout reset even though the
    // state register already reads IDLE.
    always_comb begin : grant
        req_ready = '0;
        if (rst_n && (state == IDLE) && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
            done_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // found implies req_valid[winner] & req_ready[winner].
                    if (found) begin
                        x_q    <= win_x;
                        y_q    <= win_y;
                        id_q   <= winner;
                        rr_ptr <= next_ptr;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    res_sum   <= add_s;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        done_cnt  <= done_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
`timescale 1ns/1ps
// Directed testbench for adder_arbiter (N_REQ=4).
module tb_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [23:0] req_x;
    logic [23:0] req_y;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [6:0]  res_sum;
    logic [1:0]  res_id;
    logic        res_ready;
    logic [15:0] done_cnt;

    int vecs;
    int misses;

    adder_arbiter #(
        .N_REQ (4),
        .ID_W  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_ready (res_ready),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [5:0] x, input logic [5:0] y);
        req_x[6*i +: 6] = x;
        req_y[6*i +: 6] = y;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_x     = '0;
        req_y     = '0;
        res_ready = 1'b1;
        #3;
        vecs++; if (req_ready !== 4'b0000) begin misses++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        vecs++; if (res_valid !== 1'b0) begin misses++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        vecs++; if (res_sum !== 7'd0) begin misses++; $display("FAIL reset_res_sum got=%0d exp=0", res_sum); end
        vecs++; if (res_id !== 2'd0) begin misses++; $display("FAIL reset_res_id got=%0d exp=0", res_id); end
        vecs++; if (done_cnt !== 16'd0) begin misses++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
        req_valid = 4'b0000;
        tick;
        rst_n = 1'b1;
        #1;
    endtask

    // All four continuously valid from rr_ptr=0: grants 0,1,2,3,0,1.
    task automatic test_contention;
        logic [5:0] cx [4];
        logic [5:0] cy [4];
        logic [6:0] cs [4];
        logic [3:0] eg;
        int k;
        cx = '{6'd5, 6'd17, 6'd40, 6'd63};
        cy = '{6'd9, 6'd30, 6'd22, 6'd1};
        cs = '{7'd14, 7'd47, 7'd62, 7'd64};
        for (int i = 0; i < 4; i++) set_op(i, cx[i], cy[i]);
        req_valid = 4'b1111;
        res_ready = 1'b1;
        #1;
        for (int g = 0; g < 6; g++) begin
            k  = g % 4;
            eg = 4'b0001 << k;
            vecs++; if (req_ready !== eg) begin misses++; $display("FAIL contention_grant[%0d] got=%b exp=%b", g, req_ready, eg); end
            tick;
            vecs++; if (req_ready !== 4'b0000) begin misses++; $display("FAIL contention_calc_ready[%0d] got=%b exp=0000", g, req_ready); end
            tick;
            vecs++; if (res_valid !== 1'b1 || res_sum !== cs[k] || res_id !== k[1:0])
                begin misses++; $display("FAIL contention_result[%0d] got v=%b s=%0d id=%0d exp v=1 s=%0d id=%0d", g, res_valid, res_sum, res_id, cs[k], k); end
            vecs++; if (done_cnt !== g[15:0]) begin misses++; $display("FAIL contention_done[%0d] got=%0d exp=%0d", g, done_cnt, g); end
            tick;
        end
        req_valid = 4'b0000;
        #1;
        vecs++; if (done_cnt !== 16'd6) begin misses++; $display("FAIL contention_done_final got=%0d exp=6", done_cnt); end
    endtask

    // rr_ptr=2 here; only requester 1 valid.
    task automatic test_single;
        set_op(1, 6'd63, 6'd63);
        req_valid = 4'b0010;
        #1;
        vecs++; if (req_ready !== 4'b0010) begin misses++; $display("FAIL single_grant got=%b exp=0010", req_ready); end
        tick;
        req_valid = 4'b0000;
        #1;
        vecs++; if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin misses++; $display("FAIL single_calc got rdy=%b v=%b exp rdy=0000 v=0", req_ready, res_valid); end
        tick;
        vecs++; if (res_valid !== 1'b1 || res_sum !== 7'd126 || res_id !== 2'd1)
            begin misses++; $display("FAIL single_result got v=%b s=%0d id=%0d exp v=1 s=126 id=1", res_valid, res_sum, res_id); end
        tick;
        vecs++; if (res_valid !== 1'b0 || done_cnt !== 16'd7) begin misses++; $display("FAIL single_done got v=%b cnt=%0d exp v=0 cnt=7", res_valid, done_cnt); end
    endtask

    // rr_ptr=2: requester 0 served under backpressure while requester 3 waits.
    task automatic test_backpressure;
        res_ready = 1'b0;
        set_op(0, 6'd20, 6'd21);
        req_valid = 4'b0001;
        #1;
        vecs++; if (req_ready !== 4'b0001) begin misses++; $display("FAIL bp_grant0 got=%b exp=0001", req_ready); end
        tick;
        set_op(3, 6'd50, 6'd33);
        req_valid = 4'b1000;
        #1;
        vecs++; if (req_ready !== 4'b0000) begin misses++; $display("FAIL bp_calc_ready got=%b exp=0000", req_ready); end
        tick;
        for (int c = 0; c < 5; c++) begin
            vecs++; if (res_valid !== 1'b1 || res_sum !== 7'd41 || res_id !== 2'd0 || req_ready !== 4'b0000 || done_cnt !== 16'd7)
                begin misses++; $display("FAIL bp_hold[%0d] got v=%b s=%0d id=%0d rdy=%b cnt=%0d exp v=1 s=41 id=0 rdy=0000 cnt=7", c, res_valid, res_sum, res_id, req_ready, done_cnt); end
            if (c < 4) tick;
        end
        res_ready = 1'b1;
        tick;
        vecs++; if (res_valid !== 1'b0 || done_cnt !== 16'd8) begin misses++; $display("FAIL bp_release got v=%b cnt=%0d exp v=0 cnt=8", res_valid, done_cnt); end
        vecs++; if (req_ready !== 4'b1000) begin misses++; $display("FAIL bp_grant3 got=%b exp=1000", req_ready); end
        tick;
        req_valid = 4'b0000;
        tick;
        vecs++; if (res_valid !== 1'b1 || res_sum !== 7'd83 || res_id !== 2'd3)
            begin misses++; $display("FAIL bp_result3 got v=%b s=%0d id=%0d exp v=1 s=83 id=3", res_valid, res_sum, res_id); end
        tick;
        vecs++; if (done_cnt !== 16'd9) begin misses++; $display("FAIL bp_done got=%0d exp=9", done_cnt); end
    endtask

    // rr_ptr=0: serve 2 alone, then 0 and 3 together -> 3 first, then 0.
    task automatic test_fairness;
        set_op(2, 6'd10, 6'd11);
        req_valid = 4'b0100;
        #1;
        vecs++; if (req_ready !== 4'b0100) begin misses++; $display("FAIL fair_grant2 got=%b exp=0100", req_ready); end
        tick;
        req_valid = 4'b0000;
        tick;
        vecs++; if (res_sum !== 7'd21 || res_id !== 2'd2) begin misses++; $display("FAIL fair_result2 got s=%0d id=%0d exp s=21 id=2", res_sum, res_id); end
        tick;
        set_op(0, 6'd1, 6'd2);
        set_op(3, 6'd30, 6'd31);
        req_valid = 4'b1001;
        #1;
        vecs++; if (req_ready !== 4'b1000) begin misses++; $display("FAIL fair_grant3 got=%b exp=1000", req_ready); end
        tick;
        req_valid = 4'b0001;
        tick;
        vecs++; if (res_sum !== 7'd61 || res_id !== 2'd3) begin misses++; $display("FAIL fair_result3 got s=%0d id=%0d exp s=61 id=3", res_sum, res_id); end
        tick;
        vecs++; if (req_ready !== 4'b0001) begin misses++; $display("FAIL fair_grant0 got=%b exp=0001", req_ready); end
        tick;
        req_valid = 4'b0000;
        tick;
        vecs++; if (res_sum !== 7'd3 || res_id !== 2'd0) begin misses++; $display("FAIL fair_result0 got s=%0d id=%0d exp s=3 id=0", res_sum, res_id); end
        tick;
        vecs++; if (done_cnt !== 16'd12) begin misses++; $display("FAIL fair_done got=%0d exp=12", done_cnt); end
    endtask

    task automatic test_reset_mid;
        // Reset while in CALC (rr_ptr=1, requester 2 accepted).
        set_op(2, 6'd7, 6'd8);
        req_valid = 4'b0100;
        tick;
        req_valid = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        vecs++; if (res_valid !== 1'b0 || res_sum !== 7'd0 || res_id !== 2'd0 || done_cnt !== 16'd0)
            begin misses++; $display("FAIL rst_calc got v=%b s=%0d id=%0d cnt=%0d exp all 0", res_valid, res_sum, res_id, done_cnt); end
        req_valid = 4'b1111;
        #1;
        vecs++; if (req_ready !== 4'b0000) begin misses++; $display("FAIL rst_ready_low got=%b exp=0000", req_ready); end
        tick;
        req_valid = 4'b0000;
        rst_n = 1'b1;
        // Reset while in RESP holding a result.
        res_ready = 1'b0;
        set_op(1, 6'd12, 6'd13);
        req_valid = 4'b0010;
        tick;
        req_valid = 4'b0000;
        tick;
        vecs++; if (res_valid !== 1'b1 || res_sum !== 7'd25 || res_id !== 2'd1)
            begin misses++; $display("FAIL rst_pre_resp got v=%b s=%0d id=%0d exp v=1 s=25 id=1", res_valid, res_sum, res_id); end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++; if (res_valid !== 1'b0 || res_sum !== 7'd0 || res_id !== 2'd0 || done_cnt !== 16'd0)
            begin misses++; $display("FAIL rst_resp got v=%b s=%0d id=%0d cnt=%0d exp all 0", res_valid, res_sum, res_id, done_cnt); end
        tick;
        rst_n = 1'b1;
        res_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        vecs++; if (req_ready !== 4'b0001) begin misses++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
        req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_exhaustive;
        logic [6:0] e;
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                set_op(2, x[5:0], y[5:0]);
                req_valid = 4'b0100;
                tick;
                req_valid = 4'b0000;
                tick;
                e = 7'(x + y);
                vecs++; if (res_valid !== 1'b1 || res_sum !== e || res_id !== 2'd2)
                    begin misses++; $display("FAIL exh x=%0d y=%0d got v=%b s=%0d id=%0d exp v=1 s=%0d id=2", x, y, res_valid, res_sum, res_id, e); end
                tick;
            end
        end
        vecs++; if (done_cnt !== 16'd4096) begin misses++; $display("FAIL exh_done got=%0d exp=4096", done_cnt); end
    endtask

    initial begin
        vecs   = 0;
        misses = 0;
        test_reset;
        test_contention;
        test_single;
        test_backpressure;
        test_fairness;
        test_reset_mid;
        test_exhaustive;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
        $finish;
    end

endmodule
